// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BF16 field widths, scheduler state and requester id types
package bf16_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BF16_W = 1 + EXP_W + MAN_W;
    localparam int PREC_W = 3;
    localparam logic [PREC_W-1:0] PREC_MAX = 3'd6;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} sched_state_t;
    typedef logic req_id_t;
    function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
        return p > PREC_MAX ? PREC_MAX : p;
    endfunction
endpackage

// File: rtl/bf16_rr_arb2.sv
// bf16_rr_arb2: 2-way round-robin arbiter, one grant per cycle, requester 0 first after reset
module bf16_rr_arb2 import bf16_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1
);
    req_id_t prio;
    always_comb begin
        gnt0 = en && valid0 && (!valid1 || prio == 1'b0);
        gnt1 = en && valid1 && (!valid0 || prio == 1'b1);
    end
    // the winner hands priority to the other requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio <= 1'b0;
        else if (gnt0 || gnt1) prio <= gnt0;
    end
endmodule

// File: rtl/bf16_mul_sched.sv
// bf16_mul_sched: shares one fixed-latency BF16 multiplier between two requesters with flush/drain.
// Optional grant counters when BF16_SCHED_STATS_EN is defined.
module bf16_mul_sched import bf16_pkg::*; #(
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [BF16_W-1:0] req0_a,
    input  logic [BF16_W-1:0] req0_b,
    input  logic [BF16_W-1:0] req1_a,
    input  logic [BF16_W-1:0] req1_b,
    input  logic [PREC_W-1:0] req0_prec,
    input  logic [PREC_W-1:0] req1_prec,
    output logic              mul_valid,
    output logic [BF16_W-1:0] mul_a,
    output logic [BF16_W-1:0] mul_b,
    output logic [PREC_W-1:0] mul_prec,
    input  logic [BF16_W-1:0] mul_res,
    output logic              res0_valid,
    output logic              res1_valid,
    output logic [BF16_W-1:0] res_data,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy
`ifdef BF16_SCHED_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);
    sched_state_t state, state_nx;
    logic gnt0, gnt1;
    req_id_t mul_id;
    logic [MUL_LAT-1:0] tag_v, tag_id;

    bf16_rr_arb2 u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .en(state == ST_RUN),
        .valid0(req0_valid),
        .valid1(req1_valid),
        .gnt0(gnt0),
        .gnt1(gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy = mul_valid || (|tag_v);
    assign flush_done = state == ST_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_RUN && flush_req) state_nx = ST_DRAIN;
        if (state == ST_DRAIN && !busy) state_nx = ST_DONE;
        if (state == ST_DONE && !flush_req) state_nx = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid <= 1'b0;
            mul_a <= '0;
            mul_b <= '0;
            mul_prec <= '0;
            mul_id <= 1'b0;
        end else begin
            mul_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                mul_a <= gnt1 ? req1_a : req0_a;
                mul_b <= gnt1 ? req1_b : req0_b;
                mul_prec <= clamp_prec(gnt1 ? req1_prec : req0_prec);
                mul_id <= gnt1;
            end
        end
    end

    // tag MSB lines up with mul_res of the matching issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_id <= '0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res_data <= '0;
        end else begin
            tag_v <= MUL_LAT'({tag_v, mul_valid});
            tag_id <= MUL_LAT'({tag_id, mul_id});
            res0_valid <= tag_v[MUL_LAT-1] && !tag_id[MUL_LAT-1];
            res1_valid <= tag_v[MUL_LAT-1] && tag_id[MUL_LAT-1];
            if (tag_v[MUL_LAT-1]) res_data <= mul_res;
        end
    end

`ifdef BF16_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (gnt1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bf16_mul_sched.sv
// tb_bf16_mul_sched: directed, table-driven checks of arbitration, issue, result return, flush and reset
module tb_bf16_mul_sched;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_prec = '0, req1_prec = '0;
    logic mul_valid;
    logic [15:0] mul_a, mul_b, mul_res;
    logic [2:0] mul_prec;
    logic res0_valid, res1_valid;
    logic [15:0] res_data;
    logic flush_req = 1'b0;
    logic flush_done, busy;
`ifdef BF16_SCHED_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int n_chk = 0;
    int n_pass = 0;

    bf16_mul_sched #(.MUL_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_prec(req0_prec), .req1_prec(req1_prec),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_prec(mul_prec),
        .mul_res(mul_res),
        .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
`ifdef BF16_SCHED_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] p);
        return (a ^ {b[7:0], b[15:8]}) + {13'd0, p};
    endfunction

    function automatic logic [2:0] clampp(input logic [2:0] p);
        return p > 3'd6 ? 3'd6 : p;
    endfunction

    // external multiplier: fixed L-cycle latency
    logic [15:0] mq [1:L];
    always @(posedge clk) begin
        mq[1] <= mul_valid ? mul_model(mul_a, mul_b, mul_prec) : 16'h0000;
        for (int k = 2; k <= L; k++) mq[k] <= mq[k-1];
    end
    assign mul_res = mq[L];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v0, v1;
        logic [15:0] a0, b0, a1, b1;
        logic [2:0] p0, p1;
        logic g0, g1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int pulses;
        logic [15:0] exp_q [6];
        logic [15:0] ea, eb;
        logic [2:0] ep;
        vecs[0] = '{1, 0, 16'h3F80, 16'h4000, 16'h0000, 16'h0000, 3'd6, 3'd0, 1, 0};
        vecs[1] = '{0, 1, 16'h0000, 16'h0000, 16'h4040, 16'hBF80, 3'd0, 3'd7, 0, 1};
        vecs[2] = '{1, 1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 3'd2, 3'd5, 1, 0};
        vecs[3] = '{1, 1, 16'h4100, 16'h4200, 16'hC100, 16'hC200, 3'd7, 3'd1, 0, 1};
        vecs[4] = '{1, 0, 16'h7F7F, 16'h0080, 16'h0000, 16'h0000, 3'd3, 3'd0, 1, 0};
        vecs[5] = '{0, 1, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 3'd0, 3'd0, 0, 1};
        vecs[6] = '{1, 1, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 3'd4, 3'd6, 1, 0};

        tick();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_mul_valid", {15'd0, mul_valid}, 16'd0);
        chk("rst_res_valid", {14'd0, res1_valid, res0_valid}, 16'd0);
        chk("rst_flush_done", {15'd0, flush_done}, 16'd0);
        chk("rst_mul_a", mul_a, 16'd0);
        chk("rst_res_data", res_data, 16'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            tick();
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_prec = vecs[i].p0;
            req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_prec = vecs[i].p1;
            #1;
            chk($sformatf("v%0d_ready0", i), {15'd0, req0_ready}, {15'd0, vecs[i].g0});
            chk($sformatf("v%0d_ready1", i), {15'd0, req1_ready}, {15'd0, vecs[i].g1});
            ea = vecs[i].g1 ? vecs[i].a1 : vecs[i].a0;
            eb = vecs[i].g1 ? vecs[i].b1 : vecs[i].b0;
            ep = clampp(vecs[i].g1 ? vecs[i].p1 : vecs[i].p0);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("v%0d_mul_valid", i), {15'd0, mul_valid}, 16'd1);
            chk($sformatf("v%0d_mul_a", i), mul_a, ea);
            chk($sformatf("v%0d_mul_b", i), mul_b, eb);
            chk($sformatf("v%0d_mul_prec", i), {13'd0, mul_prec}, {13'd0, ep});
            tick(); tick(); tick();
            chk($sformatf("v%0d_res_early", i), {14'd0, res1_valid, res0_valid}, 16'd0);
            tick();
            chk($sformatf("v%0d_res_valid", i), {14'd0, res1_valid, res0_valid}, {14'd0, vecs[i].g1, vecs[i].g0});
            chk($sformatf("v%0d_res_data", i), res_data, mul_model(ea, eb, ep));
            chk($sformatf("v%0d_busy", i), {15'd0, busy}, 16'd0);
            tick();
            chk($sformatf("v%0d_res_pulse", i), {14'd0, res1_valid, res0_valid}, 16'd0);
        end

        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c < 6) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_a = 16'h3F80 + 16'(c); req0_b = 16'h4000 ^ 16'(c); req0_prec = 3'(c);
                req1_a = 16'hC000 + 16'(c); req1_b = 16'h3E00 + 16'(c); req1_prec = 3'(7 - c);
                exp_q[c] = (c % 2 == 0) ? mul_model(req0_a, req0_b, clampp(req0_prec))
                                        : mul_model(req1_a, req1_b, clampp(req1_prec));
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (c < 6) begin
                chk($sformatf("rr%0d_ready0", c), {15'd0, req0_ready}, {15'd0, c % 2 == 0});
                chk($sformatf("rr%0d_ready1", c), {15'd0, req1_ready}, {15'd0, c % 2 == 1});
            end
            if (c >= 5 && c < 11) begin
                chk($sformatf("rr%0d_res0", c), {15'd0, res0_valid}, {15'd0, (c - 5) % 2 == 0});
                chk($sformatf("rr%0d_res1", c), {15'd0, res1_valid}, {15'd0, (c - 5) % 2 == 1});
                chk($sformatf("rr%0d_data", c), res_data, exp_q[c - 5]);
            end
        end

        do_reset();
        pulses = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            req0_valid = c <= 11;
            req0_prec = 3'd1;
            flush_req = c >= 2 && c <= 9;
            #1;
            if (c >= 3 && c <= 8 && res0_valid) pulses++;
            if (c <= 2) chk($sformatf("fl%0d_ready0", c), {15'd0, req0_ready}, 16'd1);
            if (c == 3) chk("fl_ready_off", {15'd0, req0_ready}, 16'd0);
            if (c == 7) chk("fl_last_res", {14'd0, flush_done, res0_valid}, 16'd1);
            if (c == 8) chk("fl_done_rise", {14'd0, busy, flush_done}, 16'd1);
            if (c == 8) chk("fl_res_count", 16'(pulses), 16'd3);
            if (c == 9 || c == 10) chk($sformatf("fl%0d_done_hold", c), {14'd0, flush_done, req0_ready}, 16'd2);
            if (c == 11) chk("fl_rerun", {14'd0, flush_done, req0_ready}, 16'd1);
            if (c == 16) chk("fl_rerun_res", {15'd0, res0_valid}, 16'd1);
        end

        do_reset();
        tick();
        req1_valid = 1'b1;
        #1;
        chk("rs_ready1", {15'd0, req1_ready}, 16'd1);
        tick();
        req1_valid = 1'b0; req0_valid = 1'b1;
        #1;
        chk("rs_ready0", {15'd0, req0_ready}, 16'd1);
        tick();
        req0_valid = 1'b0;
        chk("rs_inflight", {14'd0, busy, mul_valid}, 16'd3);
        rst_n = 1'b0;
        #1;
        chk("rs_async_clear", {13'd0, flush_done, busy, mul_valid}, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (res0_valid || res1_valid) pulses++;
        end
        chk("rs_no_results", 16'(pulses), 16'd0);
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rs_ptr_reset", {14'd0, req1_ready, req0_ready}, 16'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();

`ifdef BF16_SCHED_STATS_EN
        do_reset();
        tick();
        req0_valid = 1'b1;
        for (int c = 0; c < 70000; c++) tick();
        req0_valid = 1'b0;
        tick();
        chk("stats_cnt0_sat", grant_cnt0, 16'hFFFF);
        chk("stats_cnt1", grant_cnt1, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bf16_mul_sched.md
BF16_MUL_SCHED -- requirements
Module: bf16_mul_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, the fixed multiplier latency in cycles from mul_valid to mul_res; legal values are 1..8.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk in 1, the single clock, rising edge.
REQ-003 rst_n in 1: asynchronous assert, active-low reset.
REQ-004 req0_valid/req1_valid in 1 each: operand-pair request from requester 0/1.
REQ-005 req0_ready/req1_ready out 1 each: request accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b in 16 each: BFloat16 operands (sign [15], exponent [14:7], mantissa [6:0]).
REQ-007 req0_prec/req1_prec in 3 each: retained mantissa bits minus 1 (0..6 means 1..7 bits).
REQ-008 mul_valid out 1, mul_a out 16, mul_b out 16, mul_prec out 3: issue port to the shared variable-precision multiplier.
REQ-009 mul_res in 16: multiplier product, valid exactly MUL_LAT cycles after the matching mul_valid.
REQ-010 res0_valid/res1_valid out 1, res_data out 16: result return, no backpressure.
REQ-011 flush_req in 1, flush_done out 1, busy out 1: drain control and status.

Function
REQ-012 SHALL be an FSM with states RUN, DRAIN and DONE; reset enters RUN.
REQ-013 In RUN, at most one request SHALL be granted per cycle; grant means readyN=1 while validN=1.
REQ-014 When only one requester is valid, that requester SHALL win.
REQ-015 When both are valid, round-robin SHALL apply: the requester not granted most recently wins; after reset, requester 0 has priority.
REQ-016 readyN SHALL be combinational from validN and arbiter state, and SHALL be 0 outside RUN.
REQ-017 On a grant, mul_valid, mul_a, mul_b and mul_prec SHALL be registered and driven the next cycle (1-cycle issue latency).
REQ-018 mul_valid SHALL be 0 in any cycle without an issue.
REQ-019 A MUL_LAT-deep tag shift register SHALL carry {valid, requester id} alongside each issue.
REQ-020 When the tag emerges, res_data SHALL equal mul_res, registered, and exactly the owning resN_valid SHALL pulse for 1 cycle; end-to-end latency is MUL_LAT+2 cycles from grant.
REQ-021 Throughput SHALL be 1 op/cycle sustained; the two requesters alternate under continuous contention.
REQ-022 When req_prec is greater than 6 it SHALL be clamped to 6 on issue.
REQ-023 busy SHALL be 1 while any tag is valid or mul_valid is 1.
REQ-024 flush_req sampled 1 in RUN SHALL move the FSM to DRAIN; a grant in that same cycle still completes.
REQ-025 DRAIN SHALL advance to DONE once busy=0.
REQ-026 DONE SHALL hold flush_done=1 until flush_req=0, then return to RUN.
REQ-027 Tag shifting and results SHALL continue in every state.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear all tags, mul_valid, resN_valid, flush_done and busy.
REQ-029 Assertion of rst_n SHALL set the FSM to RUN and the round-robin pointer to requester 0.
REQ-030 Assertion of rst_n SHALL set mul_a, mul_b, mul_prec and res_data to 0.
REQ-031 In-flight operations SHALL be discarded by reset; no result is produced for them.

Configuration
REQ-032 With BF16_SCHED_STATS_EN defined, two 16-bit saturating counters SHALL exist, grant_cnt0 and grant_cnt1 (out 16 each), counting grants per requester and cleared by reset.
REQ-033 Without BF16_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-034 A shared package bf16_pkg SHALL hold the BF16 field width constants (EXP_W=8, MAN_W=7), the state enum and the requester-id type.
REQ-035 One sub-module, bf16_rr_arb2 (2-way round-robin arbiter), SHALL be instantiated.

Verification
REQ-036 MUL_LAT=3, req0 only, a=0x3F80, b=0x4000, prec=6 -> req0_ready=1; mul_valid the next cycle carrying 0x3F80/0x4000/6; res0_valid at grant+5; res_data=model mul_res.
REQ-037 Both valid for 6 cycles from reset -> grants 0,1,0,1,0,1; results return in the same order on res0/res1.
REQ-038 prec=7 on req1 -> mul_prec=6.
REQ-039 3 back-to-back issues then flush_req=1 -> ready=0 from the next cycle; flush_done rises after the last res pulse; clearing flush_req returns to RUN and readies reassert.
REQ-040 rst_n=0 pulsed while 2 ops are in flight -> no resN_valid for them; busy=0 immediately.
REQ-041 BF16_SCHED_STATS_EN defined, 70000 req0 grants -> grant_cnt0=0xFFFF.
